// File: rtl/dtu_credit_arb_pkg.sv
// Shared DTU types: error codes, output-stage states and the default credit pool size.
package lynxTypes;

  localparam int unsigned DTU_CRED_BEATS = 64;

  typedef enum logic [1:0] {
    DTU_ERR_LEN   = 2'd0,
    DTU_ERR_ROUTE = 2'd1,
    DTU_ERR_UNSOL = 2'd2
  } dtu_err_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } dtu_stage_t;

  // Index width for an n-way select, never narrower than one bit.
  function automatic int unsigned dtu_chan_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dtu_credit_arb_arb.sv
// N-way round-robin arbiter; the search starts at the pointer, which moves past each winner.
module dtu_rr_arb
  import lynxTypes::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IDX_BITS = dtu_chan_bits(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        elig,
  input  logic                en,
  output logic [N-1:0]        gnt_c,
  output logic [IDX_BITS-1:0] idx_c,
  output logic                any_c
);

  logic [IDX_BITS-1:0] ptr;
  logic [IDX_BITS:0]   cand;

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      cand = (IDX_BITS+1)'(ptr) + (IDX_BITS+1)'(k);
      if (cand >= (IDX_BITS+1)'(N)) cand = cand - (IDX_BITS+1)'(N);
      if (!any_c && elig[cand[IDX_BITS-1:0]]) begin
        any_c = 1'b1;
        idx_c = cand[IDX_BITS-1:0];
      end
    end
    if (!en) any_c = 1'b0;
    if (any_c) gnt_c[idx_c] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (any_c) begin
      ptr <= (idx_c == IDX_BITS'(N - 1)) ? '0 : idx_c + IDX_BITS'(1);
    end
  end

endmodule

// File: rtl/dtu_credit_arb.sv
// Multi-channel credit arbiter: round-robin request issue gated by per-channel data credits,
// tid-steered return data restoring credits. Optional route check: DTU_ROUTE_CHECK_EN.
module dtu_credit_arb
  import lynxTypes::*;
#(
  parameter int unsigned N_CHAN     = 4,
  parameter int unsigned DATA_BITS  = 512,
  parameter int unsigned ADDR_BITS  = 48,
  parameter int unsigned LEN_BITS   = 16,
  parameter int unsigned CRED_BEATS = DTU_CRED_BEATS,
  localparam int unsigned CHAN_BITS = dtu_chan_bits(N_CHAN),
  localparam int unsigned CNT_BITS  = $clog2(CRED_BEATS + 1),
  localparam int unsigned KEEP_BITS = DATA_BITS / 8
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [N_CHAN-1:0]             s_req_valid,
  output logic [N_CHAN-1:0]             s_req_ready,
  input  logic [N_CHAN*ADDR_BITS-1:0]   s_req_addr,
  input  logic [N_CHAN*LEN_BITS-1:0]    s_req_len,
  output logic                          m_req_valid,
  input  logic                          m_req_ready,
  output logic [ADDR_BITS-1:0]          m_req_addr,
  output logic [LEN_BITS-1:0]           m_req_len,
  output logic [CHAN_BITS-1:0]          m_req_chan,
  input  logic [DATA_BITS-1:0]          s_axis_tdata,
  input  logic [KEEP_BITS-1:0]          s_axis_tkeep,
  input  logic                          s_axis_tlast,
  input  logic [CHAN_BITS-1:0]          s_axis_tid,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic [N_CHAN*DATA_BITS-1:0]   m_axis_tdata,
  output logic [N_CHAN*KEEP_BITS-1:0]   m_axis_tkeep,
  output logic [N_CHAN-1:0]             m_axis_tlast,
  output logic [N_CHAN-1:0]             m_axis_tvalid,
  input  logic [N_CHAN-1:0]             m_axis_tready,
  input  logic [N_CHAN-1:0]             route_cap,
  output logic                          err_valid,
  output logic [CHAN_BITS-1:0]          err_chan,
  output logic [1:0]                    err_code,
  output logic [N_CHAN*CNT_BITS-1:0]    cred_avail
);

  logic [CNT_BITS-1:0]  cred   [N_CHAN];
  logic [CNT_BITS-1:0]  cred_n [N_CHAN];
  logic [LEN_BITS-1:0]  req_len  [N_CHAN];
  logic [ADDR_BITS-1:0] req_addr [N_CHAN];
  logic [N_CHAN-1:0]    bad_len, deny, rej, elig, gnt, beat, unsol;
  logic [LEN_BITS:0]    sum;
  logic [CHAN_BITS-1:0] win;
  logic                 any, en, issue, reject, unsol_any;
  dtu_stage_t           state, state_n;

`ifndef DTU_ROUTE_CHECK_EN
  logic unused_route_cap;
  assign unused_route_cap = ^route_cap;
`endif

  // Per-channel request decode and eligibility.
  always_comb begin
    for (int i = 0; i < N_CHAN; i++) begin
      req_len[i]  = s_req_len[i*LEN_BITS +: LEN_BITS];
      req_addr[i] = s_req_addr[i*ADDR_BITS +: ADDR_BITS];
      bad_len[i]  = (req_len[i] == '0) || (req_len[i] > LEN_BITS'(CRED_BEATS));
`ifdef DTU_ROUTE_CHECK_EN
      deny[i]     = !route_cap[i];
`else
      deny[i]     = 1'b0;
`endif
      rej[i]      = bad_len[i] || deny[i];
      elig[i]     = s_req_valid[i] && (rej[i] || (LEN_BITS'(cred[i]) >= req_len[i]));
    end
  end

  assign en = (state == ST_EMPTY) || m_req_ready;

  dtu_rr_arb #(.N(N_CHAN)) u_arb (
    .clk   (aclk),
    .rst   (areset),
    .elig  (elig),
    .en    (en),
    .gnt_c (gnt),
    .idx_c (win),
    .any_c (any)
  );

  assign s_req_ready = gnt;
  assign issue       = any && !rej[win];
  assign reject      = any && rej[win];
  assign m_req_valid = (state == ST_FULL);

  // Output stage state register.
  always_ff @(posedge aclk) begin
    if (areset) state <= ST_EMPTY;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_EMPTY: if (issue) state_n = ST_FULL;
      ST_FULL:  if (m_req_ready && !issue) state_n = ST_EMPTY;
      default:  state_n = ST_EMPTY;
    endcase
  end

  // Issued request payload; held while the stage waits on m_req_ready.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_req_addr <= '0;
      m_req_len  <= '0;
      m_req_chan <= '0;
    end else if (issue) begin
      m_req_addr <= req_addr[win];
      m_req_len  <= req_len[win];
      m_req_chan <= win;
    end
  end

  // Return data steering by tid; an out-of-range tid is accepted and dropped.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = '0;
    m_axis_tvalid = '0;
    s_axis_tready = 1'b1;
    for (int i = 0; i < N_CHAN; i++) begin
      m_axis_tdata[i*DATA_BITS +: DATA_BITS] = s_axis_tdata;
      m_axis_tkeep[i*KEEP_BITS +: KEEP_BITS] = s_axis_tkeep;
      m_axis_tlast[i] = s_axis_tlast;
      if (s_axis_tid == CHAN_BITS'(i)) begin
        m_axis_tvalid[i] = s_axis_tvalid;
        s_axis_tready    = m_axis_tready[i];
      end
    end
  end

  assign beat = m_axis_tvalid & m_axis_tready;

  // Issue and return on the same channel fold into one update; overflow saturates and flags.
  always_comb begin
    sum   = '0;
    unsol = '0;
    for (int i = 0; i < N_CHAN; i++) begin
      sum = (LEN_BITS+1)'(cred[i]) + (LEN_BITS+1)'(beat[i]);
      if (issue && (win == CHAN_BITS'(i))) sum = sum - (LEN_BITS+1)'(req_len[i]);
      if (sum > (LEN_BITS+1)'(CRED_BEATS)) begin
        cred_n[i] = CNT_BITS'(CRED_BEATS);
        unsol[i]  = 1'b1;
      end else begin
        cred_n[i] = CNT_BITS'(sum);
      end
    end
  end

  assign unsol_any = |unsol;

  always_ff @(posedge aclk) begin
    for (int i = 0; i < N_CHAN; i++) begin
      if (areset) cred[i] <= CNT_BITS'(CRED_BEATS);
      else        cred[i] <= cred_n[i];
    end
  end

  always_comb begin
    for (int i = 0; i < N_CHAN; i++) cred_avail[i*CNT_BITS +: CNT_BITS] = cred[i];
  end

  // Error pulse: a reject outranks an unsolicited beat; the loser is dropped.
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_valid <= 1'b0;
      err_chan  <= '0;
      err_code  <= 2'd0;
    end else begin
      err_valid <= reject || unsol_any;
      if (reject) begin
        err_chan <= win;
        err_code <= bad_len[win] ? DTU_ERR_LEN : DTU_ERR_ROUTE;
      end else if (unsol_any) begin
        err_chan <= s_axis_tid;
        err_code <= DTU_ERR_UNSOL;
      end
    end
  end

endmodule

// File: tb/tb_dtu_credit_arb.sv
// Directed bench for dtu_credit_arb (N_CHAN=4, CRED_BEATS=64); route checks run with DTU_ROUTE_CHECK_EN.
module tb_dtu_credit_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned DB = 64;
  localparam int unsigned AB = 48;
  localparam int unsigned LB = 16;

  logic            aclk = 1'b0;
  logic            areset;
  logic [N-1:0]    s_req_valid, s_req_ready;
  logic [N*AB-1:0] s_req_addr;
  logic [N*LB-1:0] s_req_len;
  logic            m_req_valid, m_req_ready;
  logic [AB-1:0]   m_req_addr;
  logic [LB-1:0]   m_req_len;
  logic [1:0]      m_req_chan;
  logic [DB-1:0]   s_axis_tdata;
  logic [DB/8-1:0] s_axis_tkeep;
  logic            s_axis_tlast, s_axis_tvalid, s_axis_tready;
  logic [1:0]      s_axis_tid;
  logic [N*DB-1:0] m_axis_tdata;
  logic [N*DB/8-1:0] m_axis_tkeep;
  logic [N-1:0]    m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic [N-1:0]    route_cap;
  logic            err_valid;
  logic [1:0]      err_chan, err_code;
  logic [N*7-1:0]  cred_avail;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 aclk = ~aclk;

  dtu_credit_arb #(.N_CHAN(N), .DATA_BITS(DB), .ADDR_BITS(AB), .LEN_BITS(LB), .CRED_BEATS(64)) dut (
    .aclk(aclk), .areset(areset),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr), .s_req_len(s_req_len),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr), .m_req_len(m_req_len),
    .m_req_chan(m_req_chan),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tid(s_axis_tid), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .route_cap(route_cap), .err_valid(err_valid), .err_chan(err_chan), .err_code(err_code),
    .cred_avail(cred_avail)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [6:0] cred_of(input int ch);
    return cred_avail[ch*7 +: 7];
  endfunction

  task automatic set_len(input int ch, input logic [LB-1:0] len);
    s_req_len[ch*LB +: LB] = len;
  endtask

  task automatic do_reset();
    areset        = 1'b1;
    s_req_valid   = '0;
    s_req_addr    = '0;
    s_req_len     = '0;
    m_req_ready   = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tid    = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = '1;
    route_cap     = '1;
    repeat (2) tick();
    areset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [27:0] full_cred;
    full_cred = {4{7'd64}};

    do_reset();
    chk("rst_m_req_valid", m_req_valid, 0);
    chk("rst_m_req_addr", m_req_addr, 0);
    chk("rst_m_req_len", m_req_len, 0);
    chk("rst_m_req_chan", m_req_chan, 0);
    chk("rst_err_valid", err_valid, 0);
    chk("rst_err_chan", err_chan, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_cred", cred_avail, full_cred);

    // Single ch0 request, len 8
    m_req_ready = 1'b1;
    s_req_valid = 4'b0001;
    set_len(0, 16'd8);
    s_req_addr[47:0] = 48'h1000;
    #1 chk("t1_sready", s_req_ready, 4'b0001);
    tick();
    s_req_valid = '0;
    chk("t1_mvalid", m_req_valid, 1);
    chk("t1_mchan", m_req_chan, 0);
    chk("t1_mlen", m_req_len, 8);
    chk("t1_maddr", m_req_addr, 48'h1000);
    chk("t1_cred0", cred_of(0), 56);
    tick();
    chk("t1_drain", m_req_valid, 0);

    // Data steering: tid 0 with its consumer stalled, then accepted
    s_axis_tdata  = 64'hDEAD_BEEF_0123_4567;
    s_axis_tid    = 2'd0;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 4'b1110;
    #1 chk("dp_tready_stall", s_axis_tready, 0);
    chk("dp_tvalid", m_axis_tvalid, 4'b0001);
    chk("dp_tdata", m_axis_tdata[63:0], 64'hDEAD_BEEF_0123_4567);
    m_axis_tready = 4'b1111;
    #1 chk("dp_tready", s_axis_tready, 1);
    tick();
    s_axis_tvalid = 1'b0;
    chk("dp_cred0", cred_of(0), 57);
    chk("dp_noerr", err_valid, 0);

    // Round robin over four channels, len 1 each
    do_reset();
    m_req_ready = 1'b1;
    s_req_valid = 4'b1111;
    for (int c = 0; c < 4; c++) set_len(c, 16'd1);
    for (int k = 0; k < 5; k++) begin
      #1 chk("t2_gnt", s_req_ready, 64'(1) << (k % 4));
      tick();
      chk("t2_chan", m_req_chan, 64'(k % 4));
    end
    s_req_valid = '0;
    tick();
    chk("t2_cred", cred_avail, {7'd63, 7'd63, 7'd63, 7'd62});
    chk("t2_idle", m_req_valid, 0);

    // Credit exhaustion and refill on ch1
    do_reset();
    m_req_ready = 1'b1;
    s_req_valid = 4'b0010;
    set_len(1, 16'd64);
    #1 chk("t3_first", s_req_ready, 4'b0010);
    tick();
    set_len(1, 16'd1);
    #1 chk("t3_stall0", s_req_ready, 0);
    chk("t3_cred_zero", cred_of(1), 0);
    tick();
    #1 chk("t3_stall1", s_req_ready, 0);
    chk("t3_drained", m_req_valid, 0);
    s_axis_tvalid = 1'b1;
    s_axis_tid    = 2'd1;
    #1 chk("t3_stall_beat", s_req_ready, 0);
    tick();
    s_axis_tvalid = 1'b0;
    #1 chk("t3_cred_one", cred_of(1), 1);
    chk("t3_grant", s_req_ready, 4'b0010);
    chk("t3_not_yet", m_req_valid, 0);
    tick();
    s_req_valid = '0;
    chk("t3_issue", m_req_valid, 1);
    chk("t3_len", m_req_len, 1);
    chk("t3_chan", m_req_chan, 1);
    chk("t3_cred_after", cred_of(1), 0);

    // Length rejects: len 0 on ch2, len 65 on ch3
    do_reset();
    m_req_ready = 1'b1;
    s_req_valid = 4'b1100;
    set_len(2, 16'd0);
    set_len(3, 16'd65);
    #1 chk("t4_gnt2", s_req_ready, 4'b0100);
    tick();
    s_req_valid = 4'b1000;
    chk("t4_err1_v", err_valid, 1);
    chk("t4_err1_c", err_chan, 2);
    chk("t4_err1_k", err_code, 0);
    chk("t4_nomreq1", m_req_valid, 0);
    #1 chk("t4_gnt3", s_req_ready, 4'b1000);
    tick();
    s_req_valid = '0;
    chk("t4_err2_v", err_valid, 1);
    chk("t4_err2_c", err_chan, 3);
    chk("t4_err2_k", err_code, 0);
    chk("t4_nomreq2", m_req_valid, 0);
    tick();
    chk("t4_err_clr", err_valid, 0);
    chk("t4_cred", cred_avail, full_cred);

    // Backpressured stage, unsolicited beat, then drain with same-cycle issue+return on ch1
    do_reset();
    m_req_ready = 1'b0;
    s_req_valid = 4'b0001;
    set_len(0, 16'd4);
    s_req_addr[47:0] = 48'hABC;
    tick();
    s_req_valid = 4'b0010;
    set_len(1, 16'd2);
    chk("t5_full", m_req_valid, 1);
    s_axis_tvalid = 1'b1;
    s_axis_tid    = 2'd2;
    #1 chk("t5_hold_rdy0", s_req_ready, 0);
    tick();
    s_axis_tvalid = 1'b0;
    chk("t5_unsol_v", err_valid, 1);
    chk("t5_unsol_c", err_chan, 2);
    chk("t5_unsol_k", err_code, 2);
    chk("t5_cred2_sat", cred_of(2), 64);
    for (int k = 0; k < 4; k++) begin
      #1 chk("t5_hold_rdy", s_req_ready, 0);
      chk("t5_hold_len", m_req_len, 4);
      chk("t5_hold_addr", m_req_addr, 48'hABC);
      chk("t5_hold_valid", m_req_valid, 1);
      tick();
    end
    chk("t5_err_clr", err_valid, 0);
    m_req_ready   = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tid    = 2'd1;
    #1 chk("t5_regrant", s_req_ready, 4'b0010);
    tick();
    s_req_valid   = '0;
    s_axis_tvalid = 1'b0;
    chk("t5_next_valid", m_req_valid, 1);
    chk("t5_next_chan", m_req_chan, 1);
    chk("t5_next_len", m_req_len, 2);
    chk("t5_cred1_net", cred_of(1), 63);
    chk("t5_cred0", cred_of(0), 60);
    chk("t5_no_err", err_valid, 0);
    tick();
    chk("t5_drain", m_req_valid, 0);

`ifdef DTU_ROUTE_CHECK_EN
    // Route capability: ch1 denied
    do_reset();
    m_req_ready = 1'b1;
    route_cap   = 4'b1101;
    s_req_valid = 4'b0011;
    set_len(0, 16'd2);
    set_len(1, 16'd2);
    #1 chk("t6_gnt0", s_req_ready, 4'b0001);
    tick();
    s_req_valid = 4'b0010;
    chk("t6_issue0", m_req_valid, 1);
    chk("t6_chan0", m_req_chan, 0);
    #1 chk("t6_gnt1", s_req_ready, 4'b0010);
    tick();
    s_req_valid = '0;
    chk("t6_err_v", err_valid, 1);
    chk("t6_err_c", err_chan, 1);
    chk("t6_err_k", err_code, 1);
    chk("t6_no_issue", m_req_valid, 0);
    chk("t6_cred1", cred_of(1), 64);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
